// File: rtl/mpu_load_store_ctrl_if.sv
// Command, memory-stream and register-file signals of the MPU load/store sequencer.
// slave = sequencer side, master = environment (command source, memory, register file).
interface mpu_load_store_ctrl_if #(
    parameter int FP               = 64,
    parameter int M                = 3,
    parameter int N                = 3,
    parameter int MATRIX_REGISTERS = 8,
    parameter int MBITS            = $clog2(M),
    parameter int NBITS            = $clog2(N),
    parameter int MATRIX_REG_SIZE  = $clog2(MATRIX_REGISTERS)
);
    logic                       cmd_valid_in;
    logic                       cmd_ready_out;
    logic                       cmd_store_in;
    logic [MATRIX_REG_SIZE-1:0] cmd_addr_in;
    logic [MBITS:0]             cmd_m_in;
    logic [NBITS:0]             cmd_n_in;
    logic                       cmd_err_out;
    logic                       done_out;
    logic                       mem_in_valid_in;
    logic                       mem_in_ready_out;
    logic [FP-1:0]              mem_in_data_in;
    logic                       mem_out_valid_out;
    logic                       mem_out_ready_in;
    logic [FP-1:0]              mem_out_data_out;
    logic                       reg_load_en_out;
    logic [MATRIX_REG_SIZE-1:0] reg_load_addr_out;
    logic [FP-1:0]              reg_load_element_out;
    logic [MBITS:0]             reg_i_load_loc_out;
    logic [NBITS:0]             reg_j_load_loc_out;
    logic [MBITS:0]             reg_m_load_size_out;
    logic [NBITS:0]             reg_n_load_size_out;
    logic                       reg_store_en_out;
    logic [MATRIX_REG_SIZE-1:0] reg_store_addr_out;
    logic [MBITS:0]             reg_i_store_loc_out;
    logic [NBITS:0]             reg_j_store_loc_out;
    logic [FP-1:0]              reg_store_element_in;
    logic [31:0]                elem_count_out;

    modport slave (
        input  cmd_valid_in, cmd_store_in, cmd_addr_in, cmd_m_in, cmd_n_in,
        input  mem_in_valid_in, mem_in_data_in, mem_out_ready_in, reg_store_element_in,
        output cmd_ready_out, cmd_err_out, done_out, mem_in_ready_out,
        output mem_out_valid_out, mem_out_data_out,
        output reg_load_en_out, reg_load_addr_out, reg_load_element_out,
        output reg_i_load_loc_out, reg_j_load_loc_out, reg_m_load_size_out, reg_n_load_size_out,
        output reg_store_en_out, reg_store_addr_out, reg_i_store_loc_out, reg_j_store_loc_out,
        output elem_count_out
    );

    modport master (
        output cmd_valid_in, cmd_store_in, cmd_addr_in, cmd_m_in, cmd_n_in,
        output mem_in_valid_in, mem_in_data_in, mem_out_ready_in, reg_store_element_in,
        input  cmd_ready_out, cmd_err_out, done_out, mem_in_ready_out,
        input  mem_out_valid_out, mem_out_data_out,
        input  reg_load_en_out, reg_load_addr_out, reg_load_element_out,
        input  reg_i_load_loc_out, reg_j_load_loc_out, reg_m_load_size_out, reg_n_load_size_out,
        input  reg_store_en_out, reg_store_addr_out, reg_i_store_loc_out, reg_j_store_loc_out,
        input  elem_count_out
    );
endinterface

// File: rtl/mpu_load_store_ctrl.sv
// Load/store sequencer walking matrix elements row-major between memory streams and the register file.
// Optional element-transfer counter enabled by defining MPU_LSC_PERF_EN.
module mpu_load_store_ctrl #(
    parameter int FP               = 64,
    parameter int M                = 3,
    parameter int N                = 3,
    parameter int MATRIX_REGISTERS = 8,
    parameter int MBITS            = $clog2(M),
    parameter int NBITS            = $clog2(N),
    parameter int MATRIX_REG_SIZE  = $clog2(MATRIX_REGISTERS)
) (
    input logic                  clk,
    input logic                  rst,
    mpu_load_store_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_OUT, DONE} state_t;

    localparam logic [MBITS:0] M_MAX = (MBITS+1)'(M);
    localparam logic [NBITS:0] N_MAX = (NBITS+1)'(N);
    localparam logic [MBITS:0] M_ONE = (MBITS+1)'(1);
    localparam logic [NBITS:0] N_ONE = (NBITS+1)'(1);

    state_t                     state_q, state_d;
    logic [MBITS:0]             i_q, i_d, m_q, m_d;
    logic [NBITS:0]             j_q, j_d, n_q, n_d;
    logic [MATRIX_REG_SIZE-1:0] addr_q, addr_d;
    logic                       err_q, err_d;
    logic                       adv_s, last_i_s, last_j_s, cmd_bad_s;

    assign last_i_s  = (i_q == m_q - M_ONE);
    assign last_j_s  = (j_q == n_q - N_ONE);
    assign cmd_bad_s = (bus.cmd_m_in == {(MBITS+1){1'b0}}) || (bus.cmd_m_in > M_MAX) ||
                       (bus.cmd_n_in == {(NBITS+1){1'b0}}) || (bus.cmd_n_in > N_MAX);

    // Element handshake: a load beat accepted or a store beat taken by the memory side
    always_comb begin
        adv_s = 1'b0;
        if (state_q == LOAD) begin
            adv_s = bus.mem_in_valid_in;
        end else if (state_q == ST_OUT) begin
            adv_s = bus.mem_out_ready_in;
        end else begin
            adv_s = 1'b0;
        end
    end

    // Next-state, index walk and command latch
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        m_d     = m_q;
        n_d     = n_q;
        addr_d  = addr_q;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cmd_valid_in) begin
                    if (cmd_bad_s) begin
                        err_d = 1'b1;
                    end else begin
                        addr_d  = bus.cmd_addr_in;
                        m_d     = bus.cmd_m_in;
                        n_d     = bus.cmd_n_in;
                        i_d     = {(MBITS+1){1'b0}};
                        j_d     = {(NBITS+1){1'b0}};
                        state_d = bus.cmd_store_in ? ST_RD : LOAD;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD:    state_d = (adv_s && last_i_s && last_j_s) ? DONE : LOAD;
            ST_RD:   state_d = ST_OUT;
            ST_OUT: begin
                if (adv_s) begin
                    state_d = (last_i_s && last_j_s) ? DONE : ST_RD;
                end else begin
                    state_d = ST_OUT;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Row-major walk; the last element wraps both indices back to 0
        if (adv_s) begin
            if (last_j_s) begin
                j_d = {(NBITS+1){1'b0}};
                i_d = last_i_s ? {(MBITS+1){1'b0}} : i_q + M_ONE;
            end else begin
                j_d = j_q + N_ONE;
            end
        end else begin
            j_d = j_d;
        end
    end

    // FSM and command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= {(MBITS+1){1'b0}};
            j_q     <= {(NBITS+1){1'b0}};
            m_q     <= {(MBITS+1){1'b0}};
            n_q     <= {(NBITS+1){1'b0}};
            addr_q  <= {MATRIX_REG_SIZE{1'b0}};
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            m_q     <= m_d;
            n_q     <= n_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

`ifdef MPU_LSC_PERF_EN
    logic [31:0] cnt_q, cnt_d;

    // Element counter next value, wraps naturally at 32 bits
    always_comb begin
        cnt_d = cnt_q;
        if (adv_s) begin
            cnt_d = cnt_q + 32'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Element counter register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bus.elem_count_out = cnt_q;
`else
    assign bus.elem_count_out = 32'd0;
`endif

    // Enables, valids and pulses are gated by rst so a reset cycle never leaks an access
    assign bus.cmd_ready_out        = ~rst & (state_q == IDLE);
    assign bus.cmd_err_out          = ~rst & err_q;
    assign bus.done_out             = ~rst & (state_q == DONE);
    assign bus.mem_in_ready_out     = ~rst & (state_q == LOAD);
    assign bus.reg_load_en_out      = ~rst & (state_q == LOAD) & bus.mem_in_valid_in;
    assign bus.reg_load_element_out = (state_q == LOAD) ? bus.mem_in_data_in : {FP{1'b0}};
    assign bus.reg_load_addr_out    = addr_q;
    assign bus.reg_i_load_loc_out   = i_q;
    assign bus.reg_j_load_loc_out   = j_q;
    assign bus.reg_m_load_size_out  = m_q;
    assign bus.reg_n_load_size_out  = n_q;
    assign bus.reg_store_en_out     = ~rst & (state_q == ST_RD);
    assign bus.reg_store_addr_out   = addr_q;
    assign bus.reg_i_store_loc_out  = i_q;
    assign bus.reg_j_store_loc_out  = j_q;
    assign bus.mem_out_valid_out    = ~rst & (state_q == ST_OUT);
    assign bus.mem_out_data_out     = (state_q == ST_OUT) ? bus.reg_store_element_in : {FP{1'b0}};
endmodule

// File: tb/tb_mpu_load_store_ctrl.sv
// Scoreboard bench for mpu_load_store_ctrl: load, gapped load, store, backpressure, bad commands, mid-command reset.
module tb_mpu_load_store_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mpu_load_store_ctrl_if #(.FP(64), .M(3), .N(3), .MATRIX_REGISTERS(8)) bus ();

    mpu_load_store_ctrl #(.FP(64), .M(3), .N(3), .MATRIX_REGISTERS(8)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    typedef struct {
        logic [2:0]  addr;
        logic [2:0]  i;
        logic [2:0]  j;
        logic [2:0]  m;
        logic [2:0]  n;
        logic [63:0] d;
    } ld_t;

    ld_t         ld_q[$];
    logic [63:0] st_q[$];
    int          st_en_cyc[$];
    logic [63:0] rf [8][3][3];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    function automatic logic [63:0] fv(input int k);
        return $realtobits(real'(k));
    endfunction

    // Register-file model: writes on load enable, registered read on store enable
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.reg_load_en_out)
            rf[bus.reg_load_addr_out][bus.reg_i_load_loc_out][bus.reg_j_load_loc_out] <= bus.reg_load_element_out;
        if (bus.reg_store_en_out)
            bus.reg_store_element_in <= rf[bus.reg_store_addr_out][bus.reg_i_store_loc_out][bus.reg_j_store_loc_out];
    end

    // Scoreboard monitor sampling on the falling edge
    always @(negedge clk) begin
        if (bus.reg_load_en_out) begin
            checks++;
            if (ld_q.size() == 0) begin
                errors++;
                $display("FAIL load_unexpected: got enable at cycle %0d, want none", cyc);
            end else begin
                ld_t e;
                e = ld_q.pop_front();
                if (bus.reg_load_addr_out !== e.addr || bus.reg_i_load_loc_out !== e.i ||
                    bus.reg_j_load_loc_out !== e.j || bus.reg_m_load_size_out !== e.m ||
                    bus.reg_n_load_size_out !== e.n || bus.reg_load_element_out !== e.d) begin
                    errors++;
                    $display("FAIL load_beat: got a=%0d i=%0d j=%0d m=%0d n=%0d d=%h, want a=%0d i=%0d j=%0d m=%0d n=%0d d=%h",
                        bus.reg_load_addr_out, bus.reg_i_load_loc_out, bus.reg_j_load_loc_out,
                        bus.reg_m_load_size_out, bus.reg_n_load_size_out, bus.reg_load_element_out,
                        e.addr, e.i, e.j, e.m, e.n, e.d);
                end
            end
        end
        if (bus.mem_out_valid_out && bus.mem_out_ready_in) begin
            checks++;
            if (st_q.size() == 0) begin
                errors++;
                $display("FAIL store_unexpected: got data %h, want none", bus.mem_out_data_out);
            end else begin
                logic [63:0] e;
                e = st_q.pop_front();
                if (bus.mem_out_data_out !== e) begin
                    errors++;
                    $display("FAIL store_data: got %h, want %h", bus.mem_out_data_out, e);
                end
            end
        end
        if (bus.reg_store_en_out) st_en_cyc.push_back(cyc);
        if (bus.done_out) done_cnt++;
        if (bus.cmd_err_out) err_cnt++;
    end

    task automatic send_cmd(input logic st, input logic [2:0] a, input logic [2:0] m, input logic [2:0] n);
        bit ok = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid_in = 1'b1; bus.cmd_store_in = st;
        bus.cmd_addr_in = a; bus.cmd_m_in = m; bus.cmd_n_in = n;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.cmd_ready_out) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        bus.cmd_valid_in = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL cmd_accept: got ready=0 for 20 cycles, want ready=1"); end
    endtask

    task automatic wait_done(input int start, input int budget);
        for (int c = 0; c < budget && done_cnt == start; c++) @(posedge clk);
        checks++;
        if (done_cnt != start + 1) begin
            errors++;
            $display("FAIL done_wait: got %0d done pulses, want 1", done_cnt - start);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.cmd_ready_out, bus.reg_load_en_out, bus.reg_store_en_out, bus.mem_out_valid_out,
             bus.done_out, bus.cmd_err_out, bus.mem_in_ready_out} !== 7'b0) begin
            errors++; $display("FAIL reset_outputs: got nonzero control outputs, want all 0");
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready_out !== 1'b1 || bus.reg_load_addr_out !== 3'd0 || bus.reg_m_load_size_out !== 3'd0 ||
            bus.reg_n_load_size_out !== 3'd0 || bus.elem_count_out !== 32'd0) begin
            errors++; $display("FAIL reset_state: got ready=%0d addr=%0d m=%0d n=%0d cnt=%0d, want 1 0 0 0 0",
                bus.cmd_ready_out, bus.reg_load_addr_out, bus.reg_m_load_size_out, bus.reg_n_load_size_out, bus.elem_count_out);
        end
    endtask

    task automatic test_load_b2b;
        int d0 = done_cnt;
        for (int k = 0; k < 6; k++) ld_q.push_back('{3'd2, 3'(k / 3), 3'(k % 3), 3'd2, 3'd3, fv(k + 1)});
        send_cmd(1'b0, 3'd2, 3'd2, 3'd3);
        for (int k = 0; k < 6; k++) begin
            bus.mem_in_valid_in = 1'b1; bus.mem_in_data_in = fv(k + 1);
            @(negedge clk);
            checks++;
            if (bus.reg_load_en_out !== 1'b1 || bus.mem_in_ready_out !== 1'b1) begin
                errors++; $display("FAIL load_b2b_en: beat %0d got en=%0d, want 1", k, bus.reg_load_en_out);
            end
            @(posedge clk); #1;
        end
        bus.mem_in_valid_in = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done_out !== 1'b1 || bus.cmd_ready_out !== 1'b0) begin
            errors++; $display("FAIL load_b2b_done: got done=%0d ready=%0d, want 1 0", bus.done_out, bus.cmd_ready_out);
        end
        wait_done(d0, 5);
        checks++;
        if (ld_q.size() != 0) begin errors++; $display("FAIL load_b2b_count: got %0d beats missing, want 0", ld_q.size()); end
`ifdef MPU_LSC_PERF_EN
        checks++;
        if (bus.elem_count_out !== 32'd6) begin
            errors++; $display("FAIL perf_count: got %0d, want 6", bus.elem_count_out);
        end
`endif
    endtask

    task automatic test_load_gaps;
        int d0 = done_cnt;
        for (int k = 0; k < 4; k++) ld_q.push_back('{3'd5, 3'(k / 2), 3'(k % 2), 3'd2, 3'd2, fv(10 + k)});
        send_cmd(1'b0, 3'd5, 3'd2, 3'd2);
        for (int k = 0; k < 8; k++) begin
            bus.mem_in_valid_in = (k % 2 == 0); bus.mem_in_data_in = fv(10 + k / 2);
            @(negedge clk);
            checks++;
            if (k < 7 && bus.reg_load_en_out !== bus.mem_in_valid_in) begin
                errors++; $display("FAIL load_gap_en: cycle %0d got en=%0d, want %0d", k, bus.reg_load_en_out, k % 2 == 0);
            end else if (k == 7 && bus.done_out !== 1'b1) begin
                errors++; $display("FAIL load_gap_done: got done=%0d, want 1", bus.done_out);
            end
            @(posedge clk); #1;
        end
        bus.mem_in_valid_in = 1'b0;
        checks++;
        if (done_cnt != d0 + 1 || ld_q.size() != 0) begin
            errors++; $display("FAIL load_gap_count: got done=%0d left=%0d, want 1 0", done_cnt - d0, ld_q.size());
        end
    endtask

    task automatic test_store;
        int d0 = done_cnt;
        st_en_cyc.delete();
        bus.mem_out_ready_in = 1'b1;
        for (int k = 0; k < 6; k++) st_q.push_back(fv(k + 1));
        send_cmd(1'b1, 3'd2, 3'd2, 3'd3);
        wait_done(d0, 30);
        checks++;
        if (st_en_cyc.size() != 6 || st_q.size() != 0) begin
            errors++; $display("FAIL store_count: got %0d pulses %0d left, want 6 0", st_en_cyc.size(), st_q.size());
        end
        for (int k = 1; k < st_en_cyc.size(); k++) begin
            checks++;
            if (st_en_cyc[k] - st_en_cyc[k-1] != 2) begin
                errors++; $display("FAIL store_spacing: pulse %0d got gap %0d, want 2", k, st_en_cyc[k] - st_en_cyc[k-1]);
            end
        end
    endtask

    task automatic test_store_bp;
        int d0 = done_cnt;
        int hs = 0;
        int low = 0;
        st_en_cyc.delete();
        for (int k = 0; k < 6; k++) st_q.push_back(fv(k + 1));
        bus.mem_out_ready_in = 1'b1;
        send_cmd(1'b1, 3'd2, 3'd2, 3'd3);
        for (int c = 0; c < 40 && done_cnt == d0; c++) begin
            if (bus.mem_out_valid_out && hs == 2 && low < 5) begin
                bus.mem_out_ready_in = 1'b0;
                low++;
                checks++;
                if (bus.mem_out_data_out !== fv(3) || bus.reg_store_en_out !== 1'b0) begin
                    errors++; $display("FAIL store_hold: got data=%h en=%0d, want %h 0", bus.mem_out_data_out, bus.reg_store_en_out, fv(3));
                end
            end else begin
                bus.mem_out_ready_in = 1'b1;
                if (bus.mem_out_valid_out) hs++;
            end
            @(posedge clk); #1;
        end
        bus.mem_out_ready_in = 1'b1;
        checks++;
        if (low != 5 || st_en_cyc.size() != 6 || st_q.size() != 0 || done_cnt != d0 + 1) begin
            errors++; $display("FAIL store_bp: got low=%0d pulses=%0d left=%0d done=%0d, want 5 6 0 1",
                low, st_en_cyc.size(), st_q.size(), done_cnt - d0);
        end
    endtask

    task automatic test_bad_cmd;
        int d0 = done_cnt;
        int e0 = err_cnt;
        st_en_cyc.delete();
        send_cmd(1'b0, 3'd1, 3'd0, 3'd2);
        @(negedge clk);
        send_cmd(1'b1, 3'd1, 3'd2, 3'd4);
        repeat (3) @(posedge clk);
        checks++;
        if (err_cnt != e0 + 2 || done_cnt != d0 || st_en_cyc.size() != 0) begin
            errors++; $display("FAIL bad_cmd: got err=%0d done=%0d st_en=%0d, want 2 0 0", err_cnt - e0, done_cnt - d0, st_en_cyc.size());
        end
        ld_q.push_back('{3'd7, 3'd0, 3'd0, 3'd1, 3'd1, fv(42)});
        send_cmd(1'b0, 3'd7, 3'd1, 3'd1);
        bus.mem_in_valid_in = 1'b1; bus.mem_in_data_in = fv(42);
        @(posedge clk); #1;
        bus.mem_in_valid_in = 1'b0;
        wait_done(d0, 5);
    endtask

    task automatic test_reset_mid;
        int d0 = done_cnt;
        for (int k = 0; k < 2; k++) ld_q.push_back('{3'd3, 3'd0, 3'(k), 3'd2, 3'd3, fv(20 + k)});
        send_cmd(1'b0, 3'd3, 3'd2, 3'd3);
        for (int k = 0; k < 2; k++) begin
            bus.mem_in_valid_in = 1'b1; bus.mem_in_data_in = fv(20 + k);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.reg_load_en_out !== 1'b0 || bus.mem_in_ready_out !== 1'b0 || bus.done_out !== 1'b0) begin
            errors++; $display("FAIL rst_mid_gate: got en=%0d rdy=%0d done=%0d, want 0 0 0",
                bus.reg_load_en_out, bus.mem_in_ready_out, bus.done_out);
        end
        @(posedge clk); #1; rst = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.cmd_ready_out !== 1'b1 || done_cnt != d0 || ld_q.size() != 0 || bus.elem_count_out !== 32'd0) begin
            errors++; $display("FAIL rst_mid_after: got ready=%0d done=%0d left=%0d cnt=%0d, want 1 0 0 0",
                bus.cmd_ready_out, done_cnt - d0, ld_q.size(), bus.elem_count_out);
        end
        bus.mem_in_valid_in = 1'b0;
    endtask

    initial begin
        bus.cmd_valid_in = 1'b0; bus.cmd_store_in = 1'b0; bus.cmd_addr_in = 3'd0;
        bus.cmd_m_in = 3'd0; bus.cmd_n_in = 3'd0;
        bus.mem_in_valid_in = 1'b0; bus.mem_in_data_in = 64'd0; bus.mem_out_ready_in = 1'b1;
        test_reset();
        test_load_b2b();
        test_load_gaps();
        test_store();
        test_store_bp();
        test_bad_cmd();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mpu_load_store_ctrl.md
Name: mpu_load_store_ctrl

Overview:
Sequencer in front of the MPU matrix register file. Accepts one load or store command at a time and walks the (i, j) element locations row-major. Load: streams elements from the memory-side input into a chosen matrix register. Store: reads the register out element by element onto the memory-side output stream, with backpressure.

Parameters:
FP, 64, element width in bits
M, 3, max matrix rows
N, 3, max matrix columns
MATRIX_REGISTERS, 8, number of matrix registers
MBITS, $clog2(M), row index MSB (locations/sizes are [MBITS:0])
NBITS, $clog2(N), column index MSB (locations/sizes are [NBITS:0])
MATRIX_REG_SIZE, $clog2(MATRIX_REGISTERS), register address width

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
cmd_valid_in  in  1  command request
cmd_ready_out  out  1  controller idle, command accepted when valid&ready
cmd_store_in  in  1  0 = load, 1 = store
cmd_addr_in  in  MATRIX_REG_SIZE  target matrix register
cmd_m_in  in  MBITS+1  row count (1..M)
cmd_n_in  in  NBITS+1  column count (1..N)
cmd_err_out  out  1  one-cycle pulse: command rejected
done_out  out  1  one-cycle pulse: command complete
mem_in_valid_in / mem_in_ready_out  in/out  1  load element handshake
mem_in_data_in  in  FP  load element
mem_out_valid_out / mem_out_ready_in  out/in  1  store element handshake
mem_out_data_out  out  FP  store element
reg_load_en_out, reg_load_addr_out, reg_load_element_out, reg_i_load_loc_out, reg_j_load_loc_out, reg_m_load_size_out, reg_n_load_size_out  out  1/MATRIX_REG_SIZE/FP/MBITS+1/NBITS+1/MBITS+1/NBITS+1  register-file load interface
reg_store_en_out, reg_store_addr_out, reg_i_store_loc_out, reg_j_store_loc_out  out  1/MATRIX_REG_SIZE/MBITS+1/NBITS+1  register-file store interface
reg_store_element_in  in  FP  register-file read data (valid the cycle after reg_store_en_out)
elem_count_out  out  32  elements transferred (optional feature)

Behaviour:
- One clock (clk). Reset (rst) is synchronous and active high.
- Reset: state IDLE; i, j, addr, m, n = 0. All outputs are 0 except cmd_ready_out = 1 once out of reset.
- While rst is high, every enable, valid and pulse output is forced to 0, whatever the state register holds.
- Reset mid-command aborts the command. No done_out is produced. No further register-file enables are issued.
- States: IDLE, LOAD, ST_RD, ST_OUT, DONE.
- IDLE:
  - cmd_ready_out = 1.
  - On cmd_valid_in, if cmd_m_in is 0 or > M, or cmd_n_in is 0 or > N: pulse cmd_err_out next cycle, stay in IDLE, perform no register-file access.
  - Otherwise latch addr/m/n, clear i and j, and go to LOAD (cmd_store_in = 0) or ST_RD (cmd_store_in = 1).
- LOAD:
  - mem_in_ready_out = 1.
  - reg_load_en_out = mem_in_valid_in (combinational).
  - reg_load_element_out = mem_in_data_in; locations = current i, j; sizes = latched m, n.
  - On each handshake: j increments. When j = n-1, j wraps to 0 and i increments.
  - The handshake at i = m-1 and j = n-1 goes to DONE.
  - No handshake means i and j hold.
- ST_RD: reg_store_en_out = 1 for exactly one cycle with the current i, j and addr; go to ST_OUT.
- ST_OUT:
  - reg_store_en_out = 0, so the register-file output holds.
  - mem_out_valid_out = 1; mem_out_data_out = reg_store_element_in.
  - On mem_out_ready_in: advance i, j as in LOAD. Last element goes to DONE, otherwise ST_RD.
  - Valid and data stay stable while ready is low.
- Store throughput: one element per 2 cycles minimum.
- DONE: done_out = 1 for one cycle; cmd_ready_out = 0; next state IDLE.
- A command is accepted at the earliest one cycle after done_out.
- Register-file address and size outputs hold the latched values between commands.
- Index counters never exceed m-1 / n-1.

Optional Feature:
- Macro: MPU_LSC_PERF_EN.
- Defined: elem_count_out is a 32-bit counter.
  - Increments by 1 on every LOAD or ST_OUT element handshake.
  - Wraps 0xFFFFFFFF -> 0.
  - Cleared only by rst.
- Undefined: counter logic is omitted; elem_count_out is tied to 0.

Test Plan:
- Load, addr 2, m = 2, n = 3, six valid elements 1.0..6.0 back-to-back -> reg_load_en_out high for 6 consecutive cycles; (i, j) = (0,0),(0,1),(0,2),(1,0),(1,1),(1,2); sizes 2/3; done_out one cycle after the 6th handshake.
- Load with mem_in_valid_in toggled 1,0,1,0 -> enables only on valid cycles; i and j hold across gaps; 4 elements for m = 2, n = 2.
- Store of addr 2 from the first test, mem_out_ready_in always 1 -> mem_out_data_out sequence 1.0..6.0; reg_store_en_out pulses every 2nd cycle; done_out after the 6th.
- Store with mem_out_ready_in low for 5 cycles on element 3 -> valid and data held stable; no extra reg_store_en_out pulses; order preserved.
- Command with m = 0, then with n = N+1 -> cmd_err_out pulse each time; no enables; no done_out; next legal command runs normally.
- rst asserted during LOAD after 2 elements -> no enables during or after the reset cycle; cmd_ready_out = 1; no done_out. With MPU_LSC_PERF_EN: elem_count_out = 0 after reset and 6 after the first test.
